// File: rtl/vector_stream_buf.sv
// rtl/vector_stream_buf.sv - packs a beat stream into BUF_SIZE-lane vectors with optional ping-pong banks
module vector_stream_buf #(
  parameter int DATA_WID     = 8,
  parameter int BUF_SIZE     = 8,
  parameter bit DOUBLE_BUF   = 1'b1,
  parameter bit CLEAR_UNUSED = 1'b1,
  localparam int CNT_WID     = $clog2(BUF_SIZE + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WID-1:0]          dataIn,
  input  logic                         dataValid,
  input  logic                         dataLast,
  output logic                         dataReady,
  input  logic                         flush,
  output logic [DATA_WID*BUF_SIZE-1:0] vecOut,
  output logic [CNT_WID-1:0]           vecCount,
  output logic                         vecLast,
  output logic                         vecValid,
  input  logic                         vecReady
);

  localparam int VEC_WID = DATA_WID * BUF_SIZE;
  localparam logic [CNT_WID-1:0] LAST_IDX = CNT_WID'(BUF_SIZE - 1);
  localparam logic [CNT_WID-1:0] FULL_CNT = CNT_WID'(BUF_SIZE);

  // Fill bank: lanes being collected for the segment in progress.
  logic [VEC_WID-1:0] fill_q, fill_d;
  logic [CNT_WID-1:0] fill_idx_q, fill_idx_d;
  // Pending: the fill bank holds a closed segment waiting for the output bank.
  logic               pend_q, pend_d;
  logic               pend_last_q, pend_last_d;
  // Output bank: the vector currently offered to the consumer.
  logic [VEC_WID-1:0] out_q, out_d;
  logic [CNT_WID-1:0] out_cnt_q, out_cnt_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;

  logic accept;
  logic closing;
  logic close_last;
  logic out_free;

  // In single-bank mode the fill side must idle while a vector is offered, so
  // the copy into the output bank is always immediate and unobservable.
  assign dataReady = !rst && !pend_q && (fill_idx_q != FULL_CNT) &&
                     (DOUBLE_BUF || !out_valid_q);

  assign vecOut   = out_q;
  assign vecCount = out_cnt_q;
  assign vecLast  = out_last_q;
  assign vecValid = out_valid_q;

  // Next-state: write accepted beat, detect segment close, move fill bank to output bank.
  always_comb begin
    fill_d      = fill_q;
    fill_idx_d  = fill_idx_q;
    pend_d      = pend_q;
    pend_last_d = pend_last_q;
    out_d       = out_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    closing     = 1'b0;
    close_last  = 1'b0;

    accept   = dataValid && dataReady;
    out_free = !out_valid_q || vecReady;

    if (accept) begin
      fill_d[int'(fill_idx_q) * DATA_WID +: DATA_WID] = dataIn;
      fill_idx_d = fill_idx_q + CNT_WID'(1);
      closing    = dataLast || flush || (fill_idx_q == LAST_IDX);
      close_last = dataLast;
    end else if (flush && !pend_q && (fill_idx_q != '0)) begin
      closing = 1'b1;
    end

    if (out_valid_q && vecReady) begin
      out_valid_d = 1'b0;
    end

    if ((closing || pend_q) && out_free) begin
      out_d       = fill_d;
      out_cnt_d   = fill_idx_d;
      out_last_d  = pend_q ? pend_last_q : close_last;
      out_valid_d = 1'b1;
      fill_idx_d  = '0;
      pend_d      = 1'b0;
      if (CLEAR_UNUSED) begin
        fill_d = '0;
      end
    end else if (closing) begin
      pend_d      = 1'b1;
      pend_last_d = close_last;
    end
  end

  // State registers with synchronous reset that drops all buffered and published data.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q      <= '0;
      fill_idx_q  <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      out_q       <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      fill_idx_q  <= fill_idx_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      out_q       <= out_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_vector_stream_buf.sv
// tb/tb_vector_stream_buf.sv - scoreboard bench for vector_stream_buf (ping-pong and single-bank instances)
module tb_vector_stream_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance 0: BUF_SIZE=4, DOUBLE_BUF=1
  logic [7:0]  d0_in;
  logic        d0_valid, d0_last, d0_ready, d0_flush;
  logic [31:0] v0_out;
  logic [2:0]  v0_cnt;
  logic        v0_last, v0_valid, v0_ready;

  // Instance 1: BUF_SIZE=2, DOUBLE_BUF=0
  logic [7:0]  d1_in;
  logic        d1_valid, d1_last, d1_ready, d1_flush;
  logic [15:0] v1_out;
  logic [1:0]  v1_cnt;
  logic        v1_last, v1_valid, v1_ready;

  vector_stream_buf #(.DATA_WID(8), .BUF_SIZE(4), .DOUBLE_BUF(1'b1), .CLEAR_UNUSED(1'b1)) dut0 (
    .clk(clk), .rst(rst), .dataIn(d0_in), .dataValid(d0_valid), .dataLast(d0_last),
    .dataReady(d0_ready), .flush(d0_flush), .vecOut(v0_out), .vecCount(v0_cnt),
    .vecLast(v0_last), .vecValid(v0_valid), .vecReady(v0_ready)
  );

  vector_stream_buf #(.DATA_WID(8), .BUF_SIZE(2), .DOUBLE_BUF(1'b0), .CLEAR_UNUSED(1'b1)) dut1 (
    .clk(clk), .rst(rst), .dataIn(d1_in), .dataValid(d1_valid), .dataLast(d1_last),
    .dataReady(d1_ready), .flush(d1_flush), .vecOut(v1_out), .vecCount(v1_cnt),
    .vecLast(v1_last), .vecValid(v1_valid), .vecReady(v1_ready)
  );

  typedef struct {
    logic [31:0] vec;
    int          cnt;
    bit          last;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] seg0[$];
  logic [7:0] seg1[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_rdy0 = 1'b0;
  bit rand_rdy1 = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: a segment is a list of beats; it becomes a vector when it
  // reaches the lane count, sees last, or is flushed.
  function automatic void publish(int which, bit last);
    exp_t e;
    e.vec  = '0;
    e.last = last;
    if (which == 0) begin
      e.cnt = seg0.size();
      foreach (seg0[i]) e.vec[i*8 +: 8] = seg0[i];
      q0.push_back(e);
      seg0.delete();
    end else begin
      e.cnt = seg1.size();
      foreach (seg1[i]) e.vec[i*8 +: 8] = seg1[i];
      q1.push_back(e);
      seg1.delete();
    end
  endfunction

  function automatic void model_beat(int which, logic [7:0] d, bit last, bit fl);
    if (which == 0) begin
      seg0.push_back(d);
      if (seg0.size() == 4 || last || fl) publish(0, last);
    end else begin
      seg1.push_back(d);
      if (seg1.size() == 2 || last || fl) publish(1, last);
    end
  endfunction

  function automatic void model_flush(int which);
    if (which == 0 && seg0.size() > 0) publish(0, 1'b0);
    if (which == 1 && seg1.size() > 0) publish(1, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] d, input bit last, input bit fl, output bit stalled);
    int n = 0;
    stalled = 1'b0;
    while (!d0_ready && n < 200) begin
      stalled = 1'b1;
      tick();
      n++;
    end
    if (!d0_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send0_timeout: dataReady=0 expected 1");
      return;
    end
    d0_in = d; d0_last = last; d0_flush = fl; d0_valid = 1'b1;
    model_beat(0, d, last, fl);
    tick();
    d0_valid = 1'b0; d0_last = 1'b0; d0_flush = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, input bit last, input bit fl);
    int n = 0;
    while (!d1_ready && n < 200) begin
      tick();
      n++;
    end
    if (!d1_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send1_timeout: dataReady=0 expected 1");
      return;
    end
    d1_in = d; d1_last = last; d1_flush = fl; d1_valid = 1'b1;
    model_beat(1, d, last, fl);
    tick();
    d1_valid = 1'b0; d1_last = 1'b0; d1_flush = 1'b0;
  endtask

  task automatic flush0();
    d0_flush = 1'b1;
    model_flush(0);
    tick();
    d0_flush = 1'b0;
  endtask

  task automatic flush1();
    d1_flush = 1'b1;
    model_flush(1);
    tick();
    d1_flush = 1'b0;
  endtask

  // Random consumer back-pressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_rdy0) v0_ready = 1'($urandom_range(0, 1));
    if (rand_rdy1) v1_ready = 1'($urandom_range(0, 1));
  end

  // Monitor 0: any offered vector must match the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && v0_valid) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mon0_unexpected: got vector 0x%0h expected none", v0_out);
      end else begin
        check("mon0_vec", v0_out, q0[0].vec);
        check("mon0_cnt", 32'(v0_cnt), 32'(q0[0].cnt));
        check("mon0_last", 32'(v0_last), 32'(q0[0].last));
        if (v0_ready) void'(q0.pop_front());
      end
    end
  end

  // Monitor 1: same for the single-bank instance.
  always @(negedge clk) begin
    if (!rst && v1_valid) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mon1_unexpected: got vector 0x%0h expected none", v1_out);
      end else begin
        check("mon1_vec", 32'(v1_out), q1[0].vec);
        check("mon1_cnt", 32'(v1_cnt), 32'(q1[0].cnt));
        check("mon1_last", 32'(v1_last), 32'(q1[0].last));
        if (v1_ready) void'(q1.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    bit stall_any;
    int r;

    rst = 1'b1;
    d0_in = '0; d0_valid = 1'b0; d0_last = 1'b0; d0_flush = 1'b0; v0_ready = 1'b0;
    d1_in = '0; d1_valid = 1'b0; d1_last = 1'b0; d1_flush = 1'b0; v1_ready = 1'b0;
    tick();
    tick();
    check("rst_ready0", 32'(d0_ready), 0);
    check("rst_valid0", 32'(v0_valid), 0);
    check("rst_ready1", 32'(d1_ready), 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready0", 32'(d0_ready), 1);
    check("post_rst_valid0", 32'(v0_valid), 0);
    check("post_rst_cnt0", 32'(v0_cnt), 0);
    check("post_rst_out0", v0_out, 0);
    check("post_rst_ready1", 32'(d1_ready), 1);

    // Back-to-back full segments with consumer always ready.
    v0_ready = 1'b1;
    stall_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send0(8'(8'h11 * (i + 1)), 1'b0, 1'b0, st);
      stall_any |= st;
      if (i == 3) begin
        check("b2b_valid", 32'(v0_valid), 1);
        check("b2b_vec", v0_out, 32'h44332211);
        check("b2b_cnt", 32'(v0_cnt), 4);
        check("b2b_last", 32'(v0_last), 0);
      end
    end
    check("b2b_no_stall", 32'(stall_any), 0);
    tick();
    tick();

    // Short segment closed by last.
    send0(8'hA1, 1'b0, 1'b0, st);
    send0(8'hA2, 1'b1, 1'b0, st);
    check("last_cnt", 32'(v0_cnt), 2);
    check("last_flag", 32'(v0_last), 1);
    check("last_vec", v0_out, 32'h0000A2A1);
    tick();

    // Flush alone on a partial segment, then on an empty one.
    send0(8'h31, 1'b0, 1'b0, st);
    send0(8'h32, 1'b0, 1'b0, st);
    send0(8'h33, 1'b0, 1'b0, st);
    flush0();
    check("flush_valid", 32'(v0_valid), 1);
    check("flush_cnt", 32'(v0_cnt), 3);
    check("flush_last", 32'(v0_last), 0);
    check("flush_vec", v0_out, 32'h00333231);
    tick();
    flush0();
    check("flush_empty_valid", 32'(v0_valid), 0);

    // Consumer stalls across two full segments.
    v0_ready = 1'b0;
    for (int i = 0; i < 8; i++) send0(8'(8'hB0 + i), 1'b0, 1'b0, st);
    check("hold_ready_drop", 32'(d0_ready), 0);
    check("hold_vec_first", v0_out, 32'hB3B2B1B0);
    tick();
    tick();
    tick();
    check("hold_vec_stable", v0_out, 32'hB3B2B1B0);
    check("hold_ready_still0", 32'(d0_ready), 0);
    v0_ready = 1'b1;
    tick();
    v0_ready = 1'b0;
    check("hold_vec_second", v0_out, 32'hB7B6B5B4);
    check("hold_valid_second", 32'(v0_valid), 1);
    check("hold_ready_back", 32'(d0_ready), 1);
    v0_ready = 1'b1;
    tick();
    tick();

    // Reset with a vector published and two beats buffered.
    v0_ready = 1'b0;
    for (int i = 0; i < 6; i++) send0(8'(8'hC0 + i), 1'b0, 1'b0, st);
    rst = 1'b1;
    q0.delete(); seg0.delete(); q1.delete(); seg1.delete();
    tick();
    check("midrst_ready", 32'(d0_ready), 0);
    check("midrst_valid", 32'(v0_valid), 0);
    rst = 1'b0;
    #1;
    check("after_rst_valid", 32'(v0_valid), 0);
    check("after_rst_cnt", 32'(v0_cnt), 0);
    check("after_rst_out", v0_out, 0);
    check("after_rst_ready", 32'(d0_ready), 1);
    v0_ready = 1'b1;
    for (int i = 0; i < 4; i++) send0(8'(8'hD0 + i), 1'b0, 1'b0, st);
    check("fresh_vec", v0_out, 32'hD3D2D1D0);
    check("fresh_cnt", 32'(v0_cnt), 4);
    tick();

    // Randomized traffic on the ping-pong instance.
    rand_rdy0 = 1'b1;
    repeat (300) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) flush0();
      else if (r < 3) tick();
      else send0(8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, st);
    end
    rand_rdy0 = 1'b0;
    tick();
    v0_ready = 1'b1;
    repeat (10) tick();

    // Single-bank instance: input stalls while a vector is offered.
    v1_ready = 1'b0;
    send1(8'hE1, 1'b0, 1'b0);
    send1(8'hE2, 1'b0, 1'b0);
    check("sb_valid", 32'(v1_valid), 1);
    check("sb_ready_low", 32'(d1_ready), 0);
    check("sb_vec", 32'(v1_out), 32'h0000E2E1);
    tick();
    tick();
    check("sb_ready_held", 32'(d1_ready), 0);
    v1_ready = 1'b1;
    check("sb_ready_hs_cycle", 32'(d1_ready), 0);
    tick();
    check("sb_valid_after", 32'(v1_valid), 0);
    check("sb_ready_after", 32'(d1_ready), 1);
    send1(8'hF1, 1'b1, 1'b0);
    check("sb_last_cnt", 32'(v1_cnt), 1);
    check("sb_last_vec", 32'(v1_out), 32'h000000F1);
    tick();

    rand_rdy1 = 1'b1;
    repeat (120) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) flush1();
      else if (r < 3) tick();
      else send1(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
    end
    rand_rdy1 = 1'b0;
    tick();
    v1_ready = 1'b1;
    repeat (10) tick();

    check("drain_q0_empty", 32'(q0.size()), 0);
    check("drain_q1_empty", 32'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_stream_buf.md
Name: vector_stream_buf

Overview:
- Parametrised successor to the single-shot vector accumulator.
- Packs a ready/valid stream of DATA_WID-bit beats into BUF_SIZE-lane vectors and publishes each vector, with its beat count, over a ready/valid vector interface.
- A segment closes when the buffer fills, on a last marker, or on an explicit flush. After the consumer takes a vector, the block rearms without a reset.
- Optional ping-pong (fill + output bank) lets the next segment fill while the consumer holds the previous one. Used between the USB packet byte stream and descriptor/setup parsers.

Parameters:
DATA_WID, 8, beat width in bits (>=1)
BUF_SIZE, 8, lanes per vector (>=1)
DOUBLE_BUF, 1, 1 = separate fill and output banks; 0 = single bank, input stalls while a vector is published
CLEAR_UNUSED, 1, 1 = lanes at index >= vecCount read as zero; 0 = unused lanes are don't-care
CNT_WID (localparam), $clog2(BUF_SIZE+1), count width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dataIn  in  DATA_WID  input beat
dataValid  in  1  beat valid
dataLast  in  1  beat is last of segment (qualified by dataValid)
dataReady  out  1  beat accepted when dataValid && dataReady
flush  in  1  close the current partial segment
vecOut  out  DATA_WID*BUF_SIZE  vector; lane i = bits [i*DATA_WID +: DATA_WID], lane 0 = first beat
vecCount  out  CNT_WID  valid beats in vecOut, 1..BUF_SIZE
vecLast  out  1  segment was closed by dataLast
vecValid  out  1  vector available
vecReady  in  1  consumer takes the vector when vecValid && vecReady

Behaviour:
Reset:
- Reset is clk and rst: synchronous, active-high.
- While rst is high, and in the cycle after: vecValid=0, vecCount=0, vecLast=0, vecOut=0, fill index=0, pending cleared.
- dataReady=0 while rst is high; dataReady=1 in the first cycle after rst deasserts.
- Reset mid-segment discards all buffered beats and any published vector.

Fill side:
- Each accepted beat is written to lane fillIdx; fillIdx then increments.
- A segment closes on the accepted beat that makes fillIdx==BUF_SIZE, or on an accepted beat with dataLast=1.
- flush=1 with fillIdx>0 and no beat accepted closes the segment (vecLast=0).
- flush=1 together with an accepted beat: that beat is included, then the segment closes (vecLast = dataLast).
- flush with fillIdx==0 and no beat is ignored. Empty vectors are never published.

DOUBLE_BUF=1:
- The output bank is free when vecValid=0, or when vecValid && vecReady this cycle.
- Segment closes and output bank is free: the completed fill bank, including the closing beat, moves to the output bank.
  - vecValid=1 and vecCount/vecLast are updated the next cycle (latency 1 from the closing beat).
  - fillIdx returns to 0; dataReady stays 1.
- Segment closes and output bank is busy: fill side goes PENDING and dataReady=0.
  - The transfer happens in the cycle vecValid && vecReady. The new vector is visible the next cycle; dataReady=1 the next cycle.
- Back-to-back: the consumer holding vecReady=1 with full-rate input yields one vector every BUF_SIZE cycles with no input stall.

DOUBLE_BUF=0:
- dataReady = !vecValid && !rst.
- The vector is the fill bank itself. vecValid rises the cycle after the closing beat or flush.
- On vecValid && vecReady: fillIdx=0, vecValid=0, dataReady=1 the next cycle.

Output stability:
- While vecValid && !vecReady, vecOut, vecCount and vecLast hold constant.
- With CLEAR_UNUSED=1, lanes >= vecCount are zero (fill lanes are cleared when a segment restarts).

Width rules:
- vecCount saturates at BUF_SIZE; there is no wrap.
- When fillIdx==BUF_SIZE, no beat is written (dataReady=0 in that case).

Test Plan:
- BUF_SIZE=4, DOUBLE_BUF=1, vecReady=1, beats 0x11,0x22,0x33,0x44,0x55… back-to-back -> vecValid one cycle after 0x44; vecOut=0x44332211, vecCount=4, vecLast=0; dataReady never drops.
- Beats 0xA1,0xA2 with dataLast on 0xA2 -> vecCount=2, vecLast=1, vecOut=0x0000A2A1 (CLEAR_UNUSED=1).
- 3 beats, then flush alone; then flush with fillIdx=0 -> one vector, vecCount=3, vecLast=0; second flush produces nothing.
- vecReady=0 while two full segments arrive (DOUBLE_BUF=1) -> first vector holds stable; dataReady drops after 8th beat; releasing vecReady for one cycle presents the second vector next cycle and dataReady=1.
- DOUBLE_BUF=0, BUF_SIZE=2 -> dataReady=0 from the cycle vecValid rises until the cycle after the vecValid && vecReady handshake.
- rst asserted mid-segment (2 beats buffered) and with a vector pending -> next cycle vecValid=0, vecCount=0, vecOut=0; a fresh 4-beat segment publishes only the new beats.
